// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types for the paddle input path
//   state_t : digital FSM states (IDLE, ACCEL, CRUISE)
//   dir_t   : decoded joystick direction (DIR_NONE, DIR_UP, DIR_DOWN)
//   VPOS_W  : width of a paddle vertical position
//   decode_dir() : joystick pair to direction, both pressed = none
package pong_pkg;

  localparam int VPOS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  function automatic dir_t decode_dir(input logic up, input logic down);
    if (up && !down) begin
      return DIR_UP;
    end else if (down && !up) begin
      return DIR_DOWN;
    end else begin
      return DIR_NONE;
    end
  endfunction

endpackage

// File: rtl/frame_tick.sv
// rtl/frame_tick.sv - V256 synchroniser and falling-edge frame tick
//   clk    : system clock
//   _reset : asynchronous active-low reset
//   _v256  : raw active-low V256 (low = vblank region)
//   tick   : one-clk pulse, high 3 clk after the _v256 fall is sampled
module frame_tick (
  input  logic clk,
  input  logic _reset,
  input  logic _v256,
  output logic tick
);

  logic       sync1;
  logic       sync2;
  logic       sync3;
  logic [1:0] sampled;
  logic       armed;

  // The sync flops reset high, so a _v256 already low at reset release
  // would look like a fall. 'armed' is only set once a real sample of
  // _v256 has been seen high, so the first tick needs a rise then a fall.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync3   <= 1'b1;
      sampled <= 2'b00;
      armed   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync1   <= _v256;
      sync2   <= sync1;
      sync3   <= sync2;
      sampled <= {sampled[0], 1'b1};
      armed   <= armed | (sampled[1] & sync2);
      tick    <= armed & sync3 & ~sync2;
    end
  end

endmodule

// File: rtl/paddle_input.sv
// rtl/paddle_input.sv - per-player paddle position from digital or analog input
//   clk         : system clock
//   _reset      : asynchronous active-low reset
//   _v256       : active-low V256 (low = vblank region)
//   analog_en   : 1 = analog stick mode, 0 = digital up/down mode
//   joy_up      : digital up (decreases vpos)
//   joy_down    : digital down (increases vpos)
//   analog_y    : signed stick Y, -128 = top
//   paddle_vpos : registered position, updated once per frame
//   moving      : high while a digital direction is held
// Optional: PADDLE_SMOOTH_EN low-pass filters the analog target.
module paddle_input
  import pong_pkg::*;
#(
  parameter int               SPEED_MIN    = 1,
  parameter int               SPEED_MAX    = 4,
  parameter int               ACCEL_FRAMES = 2,
  parameter logic [VPOS_W-1:0] VPOS_MAX    = 8'd255,
  parameter logic [VPOS_W-1:0] VPOS_RESET  = 8'd128
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              _v256,
  input  logic              analog_en,
  input  logic              joy_up,
  input  logic              joy_down,
  input  logic [VPOS_W-1:0] analog_y,
  output logic [VPOS_W-1:0] paddle_vpos,
  output logic              moving
);

  localparam logic [VPOS_W-1:0] SPD_MIN = VPOS_W'(SPEED_MIN);
  localparam logic [VPOS_W-1:0] SPD_MAX = VPOS_W'(SPEED_MAX);
  localparam logic [7:0]        ACC_N   = 8'(ACCEL_FRAMES);

  logic              tick;
  dir_t              dir;
  dir_t              last_dir;
  state_t            state;
  state_t            nxt_state;
  logic [VPOS_W-1:0] speed;
  logic [VPOS_W-1:0] nxt_speed;
  logic [7:0]        cnt;
  logic [7:0]        nxt_cnt;
  logic [VPOS_W-1:0] nxt_vpos;
  logic [VPOS_W-1:0] raw_target;
  logic [VPOS_W-1:0] target;
  logic [VPOS_W-1:0] analog_next;

  frame_tick u_frame_tick (
    .clk    (clk),
    ._reset (_reset),
    ._v256  (_v256),
    .tick   (tick)
  );

  assign dir = decode_dir(joy_up, joy_down);

  // Saturating 9-bit step; never wraps past 0 or VPOS_MAX.
  function automatic logic [VPOS_W-1:0] move_vpos(
    input logic [VPOS_W-1:0] v,
    input dir_t              d,
    input logic [VPOS_W-1:0] spd
  );
    logic [VPOS_W:0] w;
    if (d == DIR_UP) begin
      if (spd > v) begin
        w = '0;
      end else begin
        w = {1'b0, v} - {1'b0, spd};
      end
    end else begin
      w = {1'b0, v} + {1'b0, spd};
      if (w > {1'b0, VPOS_MAX}) begin
        w = {1'b0, VPOS_MAX};
      end
    end
    return w[VPOS_W-1:0];
  endfunction

  // Offset binary: -128 maps to 0 (top), +127 maps to 255.
  always_comb begin
    raw_target = analog_y ^ 8'h80;
    target     = (raw_target > VPOS_MAX) ? VPOS_MAX : raw_target;
  end

`ifdef PADDLE_SMOOTH_EN
  logic [VPOS_W:0] smooth_sum;
  always_comb begin
    smooth_sum  = {1'b0, paddle_vpos} + {1'b0, target} + 9'd1;
    analog_next = smooth_sum[VPOS_W:1];
  end
`else
  assign analog_next = target;
`endif

  // State register
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= IDLE;
    end else if (tick) begin
      state <= nxt_state;
    end
  end

  // Next-state and next-datapath values, applied only on tick
  always_comb begin
    nxt_state = state;
    nxt_speed = speed;
    nxt_cnt   = cnt;
    nxt_vpos  = paddle_vpos;
    if (analog_en) begin
      nxt_state = IDLE;
      nxt_speed = SPD_MIN;
      nxt_cnt   = 8'd0;
      nxt_vpos  = analog_next;
    end else if (dir == DIR_NONE) begin
      nxt_state = IDLE;
      nxt_speed = SPD_MIN;
      nxt_cnt   = 8'd0;
    end else if (state == IDLE || dir != last_dir) begin
      // Fresh press, or a reversal restarting acceleration from scratch
      nxt_state = ACCEL;
      nxt_speed = SPD_MIN;
      nxt_cnt   = 8'd1;
      nxt_vpos  = move_vpos(paddle_vpos, dir, SPD_MIN);
    end else if (state == ACCEL) begin
      nxt_vpos = move_vpos(paddle_vpos, dir, speed);
      if (cnt + 8'd1 == ACC_N) begin
        nxt_cnt   = 8'd0;
        nxt_speed = speed + 8'd1;
        if (speed + 8'd1 >= SPD_MAX) begin
          nxt_state = CRUISE;
        end
      end else begin
        nxt_cnt = cnt + 8'd1;
      end
    end else begin
      nxt_vpos = move_vpos(paddle_vpos, dir, SPD_MAX);
    end
  end

  // Output decode from the registered state
  always_comb begin
    moving = (state != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      paddle_vpos <= VPOS_RESET;
      speed       <= SPD_MIN;
      cnt         <= 8'd0;
      last_dir    <= DIR_NONE;
    end else if (tick) begin
      paddle_vpos <= nxt_vpos;
      speed       <= nxt_speed;
      cnt         <= nxt_cnt;
      last_dir    <= analog_en ? DIR_NONE : dir;
    end
  end

endmodule

// File: tb/tb_paddle_input.sv
// tb/tb_paddle_input.sv - directed bench for paddle_input
module tb_paddle_input;

  logic       clk = 1'b0;
  logic       _reset;
  logic       _v256;
  logic       analog_en;
  logic       joy_up;
  logic       joy_down;
  logic [7:0] analog_y;
  logic [7:0] paddle_vpos;
  logic       moving;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  paddle_input dut (
    .clk         (clk),
    ._reset      (_reset),
    ._v256       (_v256),
    .analog_en   (analog_en),
    .joy_up      (joy_up),
    .joy_down    (joy_down),
    .analog_y    (analog_y),
    .paddle_vpos (paddle_vpos),
    .moving      (moving)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drop _v256 and sample 4 clk later (one clk after the internal tick).
  task automatic v256_fall();
    @(negedge clk) _v256 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic v256_rise();
    @(negedge clk) _v256 = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic frame(input string tag, input int exp_v, input int exp_m);
    v256_fall();
    check_eq({tag, " vpos"}, paddle_vpos, exp_v);
    check_eq({tag, " moving"}, moving, exp_m);
    v256_rise();
  endtask

  task automatic do_reset();
    @(negedge clk) _reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) _reset = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  int down_exp [8] = '{129, 130, 132, 134, 137, 140, 144, 148};
  int up_exp   [4] = '{1, 0, 0, 0};

  initial begin
    _reset    = 1'b0;
    _v256     = 1'b1;
    analog_en = 1'b0;
    joy_up    = 1'b0;
    joy_down  = 1'b0;
    analog_y  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset vpos", paddle_vpos, 128);
    check_eq("reset moving", moving, 0);
    @(negedge clk) _reset = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 3; i++) frame($sformatf("idle f%0d", i), 128, 0);

    joy_down = 1'b1;
    for (int i = 0; i < 8; i++) frame($sformatf("down f%0d", i), down_exp[i], 1);

    // Reverse from CRUISE: restarts at minimum speed
    joy_down = 1'b0;
    joy_up   = 1'b1;
    frame("reverse", 147, 1);

    joy_down = 1'b1;
    frame("both", 147, 0);
    joy_up   = 1'b0;
    joy_down = 1'b0;

`ifdef PADDLE_SMOOTH_EN
    do_reset();
    analog_en = 1'b1;
    analog_y  = 8'h7F;
    frame("smooth 1", 192, 0);
    frame("smooth 2", 224, 0);
    frame("smooth 3", 240, 0);
    analog_y = 8'h80;
    for (int i = 0; i < 7; i++) v256_fall_rise_helper();
`else
    analog_en = 1'b1;
    joy_down  = 1'b1;
    analog_y  = 8'h80;
    frame("analog 80", 0, 0);
    analog_y = 8'h00;
    frame("analog 00", 128, 0);
    analog_y = 8'h7F;
    @(negedge clk) _v256 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("analog 7F early", paddle_vpos, 128);
    @(posedge clk);
    #1;
    check_eq("analog 7F on time", paddle_vpos, 255);
    repeat (3) @(posedge clk);
    #1;
    check_eq("analog 7F stable", paddle_vpos, 255);
    v256_rise();
    joy_down = 1'b0;
    analog_y = 8'h82;
    v256_fall();
    v256_rise();
`endif
    check_eq("sat setup", paddle_vpos, 2);

    analog_en = 1'b0;
    joy_up    = 1'b1;
    for (int i = 0; i < 4; i++) frame($sformatf("up sat f%0d", i), up_exp[i], 1);
    joy_up = 1'b0;
    frame("release", 0, 0);

    // Reset with _v256 low mid-frame; joy_down held so a stray tick shows
    joy_down = 1'b1;
    @(negedge clk) _v256 = 1'b0;
    @(posedge clk);
    @(negedge clk) _reset = 1'b0;
    #1;
    check_eq("midframe reset vpos", paddle_vpos, 128);
    check_eq("midframe reset moving", moving, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) _reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no tick while low", paddle_vpos, 128);
    v256_rise();
    #1;
    check_eq("no tick on rise", paddle_vpos, 128);
    frame("first tick after reset", 129, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic v256_fall_rise_helper();
    v256_fall();
    v256_rise();
  endtask

endmodule
